// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: command-queue controller in front of the 8-bit calculator ALU.
// Commands are buffered in a small FIFO and issued to the ALU one at a time.
// Each ALU result is captured into a held response register and returned
// over a valid/ready handshake. The sequencer owns the saved-result
// accumulator and substitutes it for an operand itself, so the ALU's own
// uas input is never used.
module calc_op_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_ope,
  input  logic             cmd_uas,
  input  logic [N-1:0]     cmd_in1,
  input  logic [N-1:0]     cmd_in2,
  output logic [2:0]       alu_ope,
  output logic             alu_uas,
  output logic [N-1:0]     alu_in1,
  output logic [N-1:0]     alu_in2,
  input  logic [N-1:0]     alu_ans,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_err,
  output logic [N-1:0]     acc_out,
  output logic             err_sticky,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] OPS_ONE  = CNT_W'(1);
  localparam logic [2:0]       OPE_RST  = 3'b000;
  localparam logic [2:0]       OPE_NOT  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Command FIFO storage and bookkeeping
  logic [2:0]   q_ope_r [DEPTH];
  logic         q_uas_r [DEPTH];
  logic [N-1:0] q_in1_r [DEPTH];
  logic [N-1:0] q_in2_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  // Sequencer state
  state_t           state_r;
  logic [2:0]       op_ope_r;
  logic [2:0]       alu_ope_r;
  logic [N-1:0]     alu_in1_r;
  logic [N-1:0]     alu_in2_r;
  logic             rsp_valid_r;
  logic [N-1:0]     rsp_data_r;
  logic             rsp_err_r;
  logic [N-1:0]     acc_r;
  logic             err_sticky_r;
  logic [CNT_W-1:0] op_count_r;

  logic         full_s;
  logic         empty_s;
  logic         push_s;
  logic         pop_s;
  logic [2:0]   head_ope_s;
  logic         head_uas_s;
  logic [N-1:0] head_in1_s;
  logic [N-1:0] head_in2_s;
  logic [N-1:0] sel_in1_s;
  logic [N-1:0] sel_in2_s;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never opens a slot for a push at full.
  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign push_s  = cmd_valid & ~full_s;
  assign pop_s   = (state_r == IDLE) & ~empty_s;

  assign head_ope_s = q_ope_r[rd_ptr_r];
  assign head_uas_s = q_uas_r[rd_ptr_r];
  assign head_in1_s = q_in1_r[rd_ptr_r];
  assign head_in2_s = q_in2_r[rd_ptr_r];

  // Operand selection for the popped command: the accumulator replaces in1
  // for NOT (the only unary op) and in2 for every other op.
  always_comb begin
    sel_in1_s = head_in1_s;
    sel_in2_s = head_in2_s;
    if (head_uas_s) begin
      if (head_ope_s == OPE_NOT) begin
        sel_in1_s = acc_r;
      end else begin
        sel_in2_s = acc_r;
      end
    end else begin
      sel_in1_s = head_in1_s;
      sel_in2_s = head_in2_s;
    end
  end

  // FIFO storage, pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_ope_r[i] <= 3'b000;
        q_uas_r[i] <= 1'b0;
        q_in1_r[i] <= {N{1'b0}};
        q_in2_r[i] <= {N{1'b0}};
      end
    end else begin
      if (push_s) begin
        q_ope_r[wr_ptr_r] <= cmd_ope;
        q_uas_r[wr_ptr_r] <= cmd_uas;
        q_in1_r[wr_ptr_r] <= cmd_in1;
        q_in2_r[wr_ptr_r] <= cmd_in2;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // IDLE/EXEC/RESP sequencer with registered ALU drive, response and accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      op_ope_r     <= 3'b000;
      alu_ope_r    <= 3'b000;
      alu_in1_r    <= {N{1'b0}};
      alu_in2_r    <= {N{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= {N{1'b0}};
      rsp_err_r    <= 1'b0;
      acc_r        <= {N{1'b0}};
      err_sticky_r <= 1'b0;
      op_count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            // The ALU drive is loaded here so it is valid for the whole EXEC
            // cycle; acc cannot change before EXEC ends.
            op_ope_r  <= head_ope_s;
            alu_ope_r <= head_ope_s;
            alu_in1_r <= sel_in1_s;
            alu_in2_r <= sel_in2_s;
            state_r   <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          rsp_data_r  <= alu_ans;
          rsp_err_r   <= alu_err;
          rsp_valid_r <= 1'b1;
          alu_ope_r   <= 3'b000;
          alu_in1_r   <= {N{1'b0}};
          alu_in2_r   <= {N{1'b0}};
          if (op_ope_r == OPE_RST) begin
            acc_r        <= {N{1'b0}};
            err_sticky_r <= 1'b0;
          end else if (!alu_err) begin
            acc_r <= alu_ans;
          end else begin
            err_sticky_r <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            op_count_r  <= op_count_r + OPS_ONE;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = ~full_s;
  assign alu_ope    = alu_ope_r;
  assign alu_uas    = 1'b0;
  assign alu_in1    = alu_in1_r;
  assign alu_in2    = alu_in2_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;
  assign acc_out    = acc_r;
  assign err_sticky = err_sticky_r;
  assign busy       = (state_r != IDLE) | ~empty_s;
  assign op_count   = op_count_r;

endmodule
